// File: rtl/hdma_region_arbiter_if.sv
// Bundle of request, completion and status signals around hdma_region_arbiter.
// master: arbiter side (drives s_req_ready, m_req_*, m_done_valid, status).
// slave:  environment side (region queues, DMA engine).
interface hdma_region_arbiter_if #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned ADDR_BITS = 64,
  parameter int unsigned LEN_BITS  = 28,
  parameter int unsigned CPL_DEPTH = 16,
  parameter int unsigned SRC_BITS  = $clog2(N_REGIONS)
);
  logic [N_REGIONS-1:0]           s_req_valid;
  logic [N_REGIONS-1:0]           s_req_ready;
  logic [N_REGIONS*ADDR_BITS-1:0] s_req_paddr;
  logic [N_REGIONS*LEN_BITS-1:0]  s_req_len;
  logic [N_REGIONS-1:0]           s_req_last;
  logic                           m_req_valid;
  logic                           m_req_ready;
  logic [ADDR_BITS-1:0]           m_req_paddr;
  logic [LEN_BITS-1:0]            m_req_len;
  logic                           m_req_last;
  logic [SRC_BITS-1:0]            m_req_src;
  logic                           s_done_valid;
  logic [N_REGIONS-1:0]           m_done_valid;
  logic [$clog2(CPL_DEPTH):0]     outstanding;
  logic                           err_unexp_done;

  modport master (
    input  s_req_valid, s_req_paddr, s_req_len, s_req_last, m_req_ready, s_done_valid,
    output s_req_ready, m_req_valid, m_req_paddr, m_req_len, m_req_last, m_req_src,
    output m_done_valid, outstanding, err_unexp_done
  );

  modport slave (
    output s_req_valid, s_req_paddr, s_req_len, s_req_last, m_req_ready, s_done_valid,
    input  s_req_ready, m_req_valid, m_req_paddr, m_req_len, m_req_last, m_req_src,
    input  m_done_valid, outstanding, err_unexp_done
  );
endinterface

// File: rtl/hdma_region_arbiter.sv
// Round-robin merge of per-region host DMA requests into one channel, with an
// in-order completion FIFO that routes done pulses back to the issuing region.
// Optional feature: define MMU_ARB_LAST_LOCK_EN to lock the channel to one region
// until it issues a request with last = 1.
module hdma_region_arbiter #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned ADDR_BITS = 64,
  parameter int unsigned LEN_BITS  = 28,
  parameter int unsigned CPL_DEPTH = 16,
  parameter int unsigned SRC_BITS  = $clog2(N_REGIONS)
) (
  input logic                    aclk,
  input logic                    areset,
  hdma_region_arbiter_if.master  bus
);

  localparam int unsigned PTR_BITS = $clog2(CPL_DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           state_q;
  logic [SRC_BITS-1:0]  rr_ptr_q;
  logic [ADDR_BITS-1:0] m_req_paddr_q;
  logic [LEN_BITS-1:0]  m_req_len_q;
  logic                 m_req_last_q;
  logic [SRC_BITS-1:0]  m_req_src_q;

  logic [SRC_BITS-1:0]  fifo_q [CPL_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q;
  logic [PTR_BITS-1:0]  rd_ptr_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [N_REGIONS-1:0] m_done_valid_q;
  logic                 err_unexp_done_q;

  logic [SRC_BITS-1:0]  cand;
  logic [SRC_BITS-1:0]  grant_idx;
  logic                 grant_found;
  logic                 grant_ok;
  logic                 push;
  logic                 pop;
  logic [SRC_BITS-1:0]  rr_next;

`ifdef MMU_ARB_LAST_LOCK_EN
  logic lock_q;
`endif

  // Cyclic search for the first valid region at or above rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(N_REGIONS); i++) begin
      cand = SRC_BITS'((int'(rr_ptr_q) + i) % int'(N_REGIONS));
      if (!grant_found && bus.s_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef MMU_ARB_LAST_LOCK_EN
    // While locked only the region mid-transfer may be granted, even if idle.
    if (lock_q) begin
      grant_found = bus.s_req_valid[m_req_src_q];
      grant_idx   = m_req_src_q;
    end
`endif
  end

  // Count excludes the SEND request; only one can be in flight, so <DEPTH is safe.
  assign grant_ok = !areset && (state_q == IDLE) && grant_found &&
                    (count_q < CNT_BITS'(CPL_DEPTH));
  assign push     = (state_q == SEND) && bus.m_req_ready;
  // Legality uses the pre-cycle count; a same-cycle push does not make a done legal.
  assign pop      = bus.s_done_valid && (count_q != '0);
  assign rr_next  = (m_req_src_q == SRC_BITS'(N_REGIONS - 1)) ? '0 : m_req_src_q + 1'b1;

  assign bus.s_req_ready    = grant_ok ? (N_REGIONS'(1) << grant_idx) : '0;
  assign bus.m_req_valid    = (state_q == SEND);
  assign bus.m_req_paddr    = m_req_paddr_q;
  assign bus.m_req_len      = m_req_len_q;
  assign bus.m_req_last     = m_req_last_q;
  assign bus.m_req_src      = m_req_src_q;
  assign bus.m_done_valid   = m_done_valid_q;
  assign bus.outstanding    = count_q;
  assign bus.err_unexp_done = err_unexp_done_q;

  // Grant/send FSM, output request register and round-robin pointer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      m_req_paddr_q <= '0;
      m_req_len_q   <= '0;
      m_req_last_q  <= 1'b0;
      m_req_src_q   <= '0;
`ifdef MMU_ARB_LAST_LOCK_EN
      lock_q        <= 1'b0;
`endif
    end else if (grant_ok) begin
      state_q       <= SEND;
      m_req_paddr_q <= bus.s_req_paddr[grant_idx*ADDR_BITS +: ADDR_BITS];
      m_req_len_q   <= bus.s_req_len[grant_idx*LEN_BITS +: LEN_BITS];
      m_req_last_q  <= bus.s_req_last[grant_idx];
      m_req_src_q   <= grant_idx;
    end else if (push) begin
      state_q <= IDLE;
`ifdef MMU_ARB_LAST_LOCK_EN
      if (m_req_last_q) begin
        rr_ptr_q <= rr_next;
        lock_q   <= 1'b0;
      end else begin
        lock_q   <= 1'b1;
      end
`else
      rr_ptr_q <= rr_next;
`endif
    end
  end

  // Completion FIFO pointers and outstanding count.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Completion FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge aclk) begin
    if (push) fifo_q[wr_ptr_q] <= m_req_src_q;
  end

  // One-cycle done routing and unexpected-done error pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_done_valid_q   <= '0;
      err_unexp_done_q <= 1'b0;
    end else begin
      m_done_valid_q   <= pop ? (N_REGIONS'(1) << fifo_q[rd_ptr_q]) : '0;
      err_unexp_done_q <= bus.s_done_valid && (count_q == '0);
    end
  end

endmodule

// File: tb/tb_hdma_region_arbiter.sv
// Scoreboard bench for hdma_region_arbiter (4 regions, depth 16).
module tb_hdma_region_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AB = 64;
  localparam int unsigned LB = 28;
  localparam int unsigned CD = 16;
  localparam int unsigned SB = 2;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  hdma_region_arbiter_if #(.N_REGIONS(NR), .ADDR_BITS(AB), .LEN_BITS(LB), .CPL_DEPTH(CD),
                           .SRC_BITS(SB)) bus ();

  hdma_region_arbiter #(.N_REGIONS(NR), .ADDR_BITS(AB), .LEN_BITS(LB), .CPL_DEPTH(CD),
                        .SRC_BITS(SB)) dut (.aclk(aclk), .areset(areset), .bus(bus));

  typedef struct {
    logic [1:0]  src;
    logic [63:0] paddr;
    logic [27:0] len;
    logic        last;
  } req_t;

  typedef struct {
    int         due;
    logic [3:0] hot;
    logic       err;
  } done_t;

  req_t       exp_q[$];
  done_t      done_q[$];
  logic [1:0] mdl_fifo[$];
  int         mdl_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;
  bit spacing_en = 0;
  int last_mhs = -1;
  bit exp_issue = 0;
  logic [1:0] exp_issue_src;

  bit          r_valid[NR];
  int          r_seq[NR];
  int          r_rem[NR];
  logic [31:0] r_last[NR];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] paddr_of(input int r, input int k);
    return {16'(r + 1), 16'h00a5, 32'(k * 64)};
  endfunction

  function automatic logic [27:0] len_of(input int r, input int k);
    return 28'(r * 256 + k + 1);
  endfunction

  task automatic drive_regions();
    for (int r = 0; r < NR; r++) begin
      bus.s_req_valid[r]           = r_valid[r];
      bus.s_req_paddr[r*AB +: AB]  = paddr_of(r, r_seq[r]);
      bus.s_req_len[r*LB +: LB]    = len_of(r, r_seq[r]);
      bus.s_req_last[r]            = r_last[r][r_seq[r]];
    end
  endtask

  task automatic load(input int r, input int n, input logic [31:0] lp);
    r_valid[r] = (n > 0);
    r_seq[r]   = 0;
    r_rem[r]   = n;
    r_last[r]  = lp;
  endtask

  task automatic expect_req(input int r, input int k);
    req_t e;
    e.src   = 2'(r);
    e.paddr = paddr_of(r, k);
    e.len   = len_of(r, k);
    e.last  = r_last[r][k];
    exp_q.push_back(e);
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic cycle();
    logic [3:0] rdy;
    logic mhs;
    logic done_in;
    logic pop_ok;
    req_t e;
    done_t d;
    #1;
    rdy     = bus.s_req_ready;
    mhs     = (bus.m_req_valid === 1'b1) && (bus.m_req_ready === 1'b1);
    done_in = bus.s_done_valid;
    if (chk_en) begin
      check_eq("outstanding", 64'(bus.outstanding), 64'(mdl_cnt));
      if (done_q.size() > 0 && done_q[0].due < cyc) begin
        check_eq("done_missed", 64'(cyc), 64'(done_q[0].due));
        void'(done_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0].due == cyc) begin
        d = done_q.pop_front();
        check_eq("done_hot", 64'(bus.m_done_valid), 64'(d.hot));
        check_eq("done_err", 64'(bus.err_unexp_done), 64'(d.err));
      end else if (bus.m_done_valid != 0 || bus.err_unexp_done) begin
        check_eq("spurious_done", {bus.m_done_valid, bus.err_unexp_done}, 64'd0);
      end
      if (exp_issue) begin
        check_eq("issue_valid", 64'(bus.m_req_valid), 64'd1);
        check_eq("issue_src", 64'(bus.m_req_src), 64'(exp_issue_src));
        exp_issue = 0;
      end
      if (rdy != 0) begin
        check_eq("ready_onehot", 64'($countones(rdy)), 64'd1);
        check_eq("ready_valid", 64'(rdy & ~bus.s_req_valid), 64'd0);
      end
      if (mhs) begin
        if (exp_q.size() == 0) begin
          check_eq("req_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("req_src", 64'(bus.m_req_src), 64'(e.src));
          check_eq("req_paddr", bus.m_req_paddr, e.paddr);
          check_eq("req_len", 64'(bus.m_req_len), 64'(e.len));
          check_eq("req_last", 64'(bus.m_req_last), 64'(e.last));
          mdl_fifo.push_back(e.src);
        end
        if (spacing_en && last_mhs >= 0) check_eq("req_spacing", 64'(cyc - last_mhs), 64'd2);
        last_mhs = cyc;
      end
    end
    @(negedge aclk);
    if (areset) begin
      exp_q.delete();
      done_q.delete();
      mdl_fifo.delete();
      mdl_cnt   = 0;
      exp_issue = 0;
    end else if (chk_en) begin
      pop_ok = done_in && (mdl_cnt > 0);
      if (done_in) begin
        d.due = cyc + 1;
        if (pop_ok) begin
          d.hot = 4'b0001 << mdl_fifo.pop_front();
          d.err = 1'b0;
        end else begin
          d.hot = 4'b0000;
          d.err = 1'b1;
        end
        done_q.push_back(d);
      end
      mdl_cnt = mdl_cnt + (mhs ? 1 : 0) - (pop_ok ? 1 : 0);
      for (int r = 0; r < NR; r++) begin
        if (r_valid[r] && rdy[r]) begin
          exp_issue     = 1;
          exp_issue_src = 2'(r);
          r_seq[r]++;
          r_rem[r]--;
          if (r_rem[r] == 0) r_valid[r] = 0;
        end
      end
    end
    drive_regions();
    cyc++;
  endtask

  task automatic run_until_drained(input int budget);
    int b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      cycle();
      b--;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    cycle();
    cycle();
  endtask

  task automatic pulse_done(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_done_valid = 1'b1;
      cycle();
    end
    bus.s_done_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic wait_send(input int budget);
    int b = budget;
    while (bus.m_req_valid !== 1'b1 && b > 0) begin
      cycle();
      b--;
    end
    if (bus.m_req_valid !== 1'b1) check_eq("send_timeout", 64'(bus.m_req_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    areset = 1'b1;
    bus.m_req_ready  = 1'b0;
    bus.s_done_valid = 1'b0;
    for (int r = 0; r < NR; r++) load(r, 0, 32'h0);
    drive_regions();
    @(negedge aclk);
    repeat (3) cycle();

    // Reset values
    areset = 1'b0;
    #1;
    check_eq("rst_ready", 64'(bus.s_req_ready), 64'd0);
    check_eq("rst_valid", 64'(bus.m_req_valid), 64'd0);
    check_eq("rst_paddr", bus.m_req_paddr, 64'd0);
    check_eq("rst_len", 64'(bus.m_req_len), 64'd0);
    check_eq("rst_last", 64'(bus.m_req_last), 64'd0);
    check_eq("rst_src", 64'(bus.m_req_src), 64'd0);
    check_eq("rst_done", 64'(bus.m_done_valid), 64'd0);
    check_eq("rst_err", 64'(bus.err_unexp_done), 64'd0);
    check_eq("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk_en = 1;

    // All regions valid: src 0,1,2,3,0 two cycles apart
    bus.m_req_ready = 1'b1;
    load(0, 2, 32'hffff_ffff);
    for (int r = 1; r < NR; r++) load(r, 1, 32'hffff_ffff);
    expect_req(0, 0); expect_req(1, 0); expect_req(2, 0); expect_req(3, 0); expect_req(0, 1);
    drive_regions();
    spacing_en = 1;
    last_mhs   = -1;
    run_until_drained(40);
    spacing_en = 0;
    check_eq("out_after_all", 64'(bus.outstanding), 64'd5);
    pulse_done(5);

    // Done routing: issue 2, 0, 3 then three back-to-back dones
    load(2, 1, 32'h1); expect_req(2, 0); drive_regions(); run_until_drained(20);
    load(0, 1, 32'h1); expect_req(0, 0); drive_regions(); run_until_drained(20);
    load(3, 1, 32'h1); expect_req(3, 0); drive_regions(); run_until_drained(20);
    check_eq("out_three", 64'(bus.outstanding), 64'd3);
    pulse_done(3);
    check_eq("out_zero", 64'(bus.outstanding), 64'd0);

    // Full: 16 outstanding blocks grants; one done lets one more through
    load(1, 17, 32'hffff_ffff);
    for (int k = 0; k < 17; k++) expect_req(1, k);
    drive_regions();
    b = 80;
    while (mdl_cnt < 16 && b > 0) begin
      cycle();
      b--;
    end
    if (mdl_cnt < 16) check_eq("fill_timeout", 64'(mdl_cnt), 64'd16);
    cycle();
    repeat (5) begin
      cycle();
      check_eq("full_ready", 64'(bus.s_req_ready), 64'd0);
      check_eq("full_out", 64'(bus.outstanding), 64'd16);
      check_eq("full_valid", 64'(bus.m_req_valid), 64'd0);
    end
    check_eq("full_pending", 64'(exp_q.size()), 64'd1);
    bus.s_done_valid = 1'b1;
    cycle();
    bus.s_done_valid = 1'b0;
    run_until_drained(20);
    check_eq("full_refill", 64'(bus.outstanding), 64'd16);
    pulse_done(16);
    pulse_done(1);
    check_eq("out_after_err", 64'(bus.outstanding), 64'd0);

    // Backpressure: fields stable, no second grant while SEND stalls
    bus.m_req_ready = 1'b0;
    load(3, 1, 32'h1); expect_req(3, 0); drive_regions();
    wait_send(10);
    load(1, 1, 32'h1); expect_req(1, 0); drive_regions();
    repeat (5) begin
      cycle();
      check_eq("bp_valid", 64'(bus.m_req_valid), 64'd1);
      check_eq("bp_paddr", bus.m_req_paddr, paddr_of(3, 0));
      check_eq("bp_len", 64'(bus.m_req_len), 64'(len_of(3, 0)));
      check_eq("bp_src", 64'(bus.m_req_src), 64'd3);
      check_eq("bp_ready", 64'(bus.s_req_ready), 64'd0);
    end
    bus.m_req_ready = 1'b1;
    run_until_drained(20);
    pulse_done(2);

    // Mid-operation reset discards in-flight request and FIFO contents
    load(0, 1, 32'h1); expect_req(0, 0); drive_regions(); run_until_drained(20);
    bus.m_req_ready = 1'b0;
    load(2, 1, 32'h1); expect_req(2, 0); drive_regions();
    wait_send(10);
    for (int r = 0; r < NR; r++) load(r, 0, 32'h0);
    drive_regions();
    areset = 1'b1;
    cycle();
    cycle();
    areset = 1'b0;
    bus.m_req_ready = 1'b1;
    check_eq("mid_rst_valid", 64'(bus.m_req_valid), 64'd0);
    check_eq("mid_rst_out", 64'(bus.outstanding), 64'd0);
    cycle();
    cycle();
    pulse_done(1);

    // Last lock: region 1 sends last 0,0,1 while region 2 waits
    load(1, 3, 32'b100);
    load(2, 1, 32'h1);
`ifdef MMU_ARB_LAST_LOCK_EN
    expect_req(1, 0); expect_req(1, 1); expect_req(1, 2); expect_req(2, 0);
`else
    expect_req(1, 0); expect_req(2, 0); expect_req(1, 1); expect_req(1, 2);
`endif
    drive_regions();
    run_until_drained(30);
    pulse_done(4);
    check_eq("final_out", 64'(bus.outstanding), 64'd0);
    check_eq("final_done_q", 64'(done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
